// File: rtl/axi_ram_pkg.sv
// Shared encodings for the AXI-to-RAM shell: burst types, response codes
// and the read front-end state machine states.
package axi_ram_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ERR
    } state_t;

endpackage

// File: rtl/axi_rd_burst2ram_if.sv
// AXI4 read-address and read-data channels of one read port.
interface axi_rd_burst2ram_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 6
);
    logic [ID_WIDTH-1:0]   s_axi_arid;
    logic [ADDR_WIDTH-1:0] s_axi_araddr;
    logic [7:0]            s_axi_arlen;
    logic [2:0]            s_axi_arsize;
    logic [1:0]            s_axi_arburst;
    logic                  s_axi_arvalid;
    logic                  s_axi_arready;
    logic [ID_WIDTH-1:0]   s_axi_rid;
    logic [DATA_WIDTH-1:0] s_axi_rdata;
    logic [1:0]            s_axi_rresp;
    logic                  s_axi_rlast;
    logic                  s_axi_rvalid;
    logic                  s_axi_rready;

    modport master (
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
               s_axi_arvalid, s_axi_rready,
        input  s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
               s_axi_rvalid
    );

    modport slave (
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
               s_axi_arvalid, s_axi_rready,
        output s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
               s_axi_rvalid
    );
endinterface

// File: rtl/axi_rd_skid_fifo.sv
// Two-entry R-beat buffer; head is visible combinationally, push/pop same cycle allowed.
// Caller guarantees no push into a full buffer unless it also pops.
module axi_rd_skid_fifo #(
    parameter int DW = 128,
    parameter int IW = 6
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic [IW-1:0] push_id,
    input  logic          push_last,
    input  logic [1:0]    push_resp,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic [IW-1:0] head_id,
    output logic          head_last,
    output logic [1:0]    head_resp,
    output logic [1:0]    count
);

    logic [DW-1:0] data_q [2];
    logic [IW-1:0] id_q   [2];
    logic          last_q [2];
    logic [1:0]    resp_q [2];
    logic          wr_ptr;
    logic          rd_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                id_q[i]   <= '0;
                last_q[i] <= 1'b0;
                resp_q[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= push_data;
                id_q[wr_ptr]   <= push_id;
                last_q[wr_ptr] <= push_last;
                resp_q[wr_ptr] <= push_resp;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_data = data_q[rd_ptr];
    assign head_id   = id_q[rd_ptr];
    assign head_last = last_q[rd_ptr];
    assign head_resp = resp_q[rd_ptr];

    assert property (@(posedge clk) disable iff (!rstn) !(push && !pop && count == 2'd2));
    assert property (@(posedge clk) disable iff (!rstn) !(pop && count == 2'd0));

endmodule

// File: rtl/axi_rd_burst2ram.sv
// AXI4 read slave that expands one AR burst at a time into single-word RAM reads
// and returns beats through a 2-entry buffer; reads are credit-limited by R backpressure.
module axi_rd_burst2ram
    import axi_ram_pkg::*;
#(
    parameter int  DATA_WIDTH = 128,
    parameter int  ADDR_WIDTH = 32,
    parameter int  ID_WIDTH   = 6,
    localparam int LSB        = $clog2(DATA_WIDTH) - 3
) (
    input  logic                      clk,
    input  logic                      rstn,
    axi_rd_burst2ram_if.slave         axi,
    output logic                      o_rd,
    output logic [ADDR_WIDTH-LSB-1:0] o_raddr,
    input  logic [DATA_WIDTH-1:0]     i_rdata
);

    state_t                state;
    logic                  arready_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            cnt_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  inflight;
    logic [ID_WIDTH-1:0]   tag_id;
    logic                  tag_last;

    logic [1:0]            count;
    logic [2:0]            occ;
    logic                  pop;
    logic                  push;
    logic                  credit;
    logic                  err_push;
    logic                  at_last;
    logic [ADDR_WIDTH-1:0] step;

    // A read issued now lands in the buffer next cycle, so it may only go out
    // if the buffer can hold it even when the consumer stalls from here on.
    always_comb begin
        pop      = axi.s_axi_rready && (count != 2'd0);
        occ      = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
        credit   = occ < 3'd2;
        at_last  = cnt_q == len_q;
        o_rd     = (state == ISSUE) && credit;
        err_push = (state == ERR) && credit;
        push     = inflight || err_push;
        step     = ADDR_WIDTH'(1) << size_q;
        o_raddr  = addr_q[ADDR_WIDTH-1:LSB];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            arready_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            inflight  <= 1'b0;
            tag_id    <= '0;
            tag_last  <= 1'b0;
        end else begin
            inflight <= o_rd;
            tag_id   <= id_q;
            tag_last <= at_last;
            unique case (state)
                IDLE: begin
                    if (axi.s_axi_arvalid && arready_q) begin
                        id_q      <= axi.s_axi_arid;
                        addr_q    <= axi.s_axi_araddr;
                        len_q     <= axi.s_axi_arlen;
                        size_q    <= axi.s_axi_arsize;
                        burst_q   <= axi.s_axi_arburst;
                        cnt_q     <= '0;
                        arready_q <= 1'b0;
                        unique case (axi.s_axi_arburst)
                            BURST_FIXED, BURST_INCR, BURST_WRAP: state <= ISSUE;
                            default:                             state <= ERR;
                        endcase
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (o_rd) begin
                        cnt_q <= cnt_q + 8'd1;
                        // WRAP deliberately walks linearly like INCR
                        if (burst_q != BURST_FIXED) begin
                            addr_q <= addr_q + step;
                        end
                        if (at_last) begin
                            state     <= IDLE;
                            arready_q <= 1'b1;
                        end
                    end
                end
                ERR: begin
                    if (err_push) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (at_last) begin
                            state     <= IDLE;
                            arready_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM beats and error beats never coincide: ERR is always entered through IDLE.
    axi_rd_skid_fifo #(
        .DW (DATA_WIDTH),
        .IW (ID_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (err_push ? '0 : i_rdata),
        .push_id   (err_push ? id_q : tag_id),
        .push_last (err_push ? at_last : tag_last),
        .push_resp (err_push ? RESP_SLVERR : RESP_OKAY),
        .pop       (pop),
        .head_data (axi.s_axi_rdata),
        .head_id   (axi.s_axi_rid),
        .head_last (axi.s_axi_rlast),
        .head_resp (axi.s_axi_rresp),
        .count     (count)
    );

    assign axi.s_axi_arready = arready_q;
    assign axi.s_axi_rvalid  = count != 2'd0;

endmodule

// File: tb/tb_axi_rd_burst2ram.sv
// Bench for axi_rd_burst2ram: RAM model, R-channel monitor and a burst-level
// reference that lists expected RAM addresses and R beats per accepted AR.
module tb_axi_rd_burst2ram;

    localparam int DW = 128;
    localparam int AW = 32;
    localparam int IW = 6;
    localparam int WA = AW - 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          o_rd;
    logic [WA-1:0] o_raddr;
    logic [DW-1:0] i_rdata;

    int    cyc = 0, checks = 0, errors = 0;
    int    n_iss = 0, n_acc = 0, max_out = 0, stab_err = 0, rr_mode = 0;
    logic  rready_man = 1'b0;
    logic  prev_stall = 1'b0;
    beat_t prev_beat;
    beat_t exp_q[$], obs_q[$];
    logic [WA-1:0] exp_a[$], obs_a[$];
    int    obs_acyc[$], obs_bcyc[$];

    axi_rd_burst2ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) axi_if ();

    axi_rd_burst2ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .axi     (axi_if),
        .o_rd    (o_rd),
        .o_raddr (o_raddr),
        .i_rdata (i_rdata)
    );

    function automatic logic [DW-1:0] ram_word(input logic [WA-1:0] wa);
        logic [31:0] w;
        w = {4'h0, wa};
        return {w ^ 32'hDEAD_BEEF, w * 32'd7, ~w, w + 32'h1234_5678};
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // RAM: data valid only in the cycle after a read, garbage otherwise
    always @(posedge clk) i_rdata <= o_rd ? ram_word(o_raddr) : {4{$urandom}};

    always @(posedge clk) begin
        #1;
        if (rr_mode == 0)      axi_if.s_axi_rready = 1'b1;
        else if (rr_mode == 1) axi_if.s_axi_rready = ($urandom_range(0, 3) != 0);
        else                   axi_if.s_axi_rready = rready_man;
    end

    always @(negedge clk) begin : mon
        beat_t b;
        b.data = axi_if.s_axi_rdata;
        b.id   = axi_if.s_axi_rid;
        b.resp = axi_if.s_axi_rresp;
        b.last = axi_if.s_axi_rlast;
        if (!rstn) begin
            prev_stall = 1'b0;
            n_iss = 0;
            n_acc = 0;
        end else begin
            if (o_rd) begin
                obs_a.push_back(o_raddr);
                obs_acyc.push_back(cyc);
                n_iss++;
            end
            if (prev_stall && (!axi_if.s_axi_rvalid || b !== prev_beat)) stab_err++;
            if (axi_if.s_axi_rvalid && axi_if.s_axi_rready) begin
                obs_q.push_back(b);
                obs_bcyc.push_back(cyc);
                n_acc++;
            end
            if (n_iss - n_acc > max_out) max_out = n_iss - n_acc;
            prev_stall = axi_if.s_axi_rvalid && !axi_if.s_axi_rready;
            prev_beat  = b;
        end
    end

    task automatic clear();
        exp_q.delete(); obs_q.delete(); exp_a.delete(); obs_a.delete();
        obs_acyc.delete(); obs_bcyc.delete();
        max_out = 0; stab_err = 0;
    endtask

    // Reference: beat i reads byte address addr + i*2^size (FIXED: addr), modulo 2^32
    task automatic issue(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int hs);
        logic [AW-1:0] a;
        beat_t eb;
        bit done;
        for (int i = 0; i <= int'(len); i++) begin
            a = (burst == 2'b00) ? addr : addr + AW'(i) * (AW'(1) << size);
            eb.id   = id;
            eb.last = (i == int'(len));
            if (burst == 2'b11) begin
                eb.data = '0;
                eb.resp = 2'b10;
            end else begin
                eb.data = ram_word(a[AW-1:4]);
                eb.resp = 2'b00;
                exp_a.push_back(a[AW-1:4]);
            end
            exp_q.push_back(eb);
        end
        hs = -1;
        done = 1'b0;
        @(negedge clk);
        axi_if.s_axi_arid    = id;
        axi_if.s_axi_araddr  = addr;
        axi_if.s_axi_arlen   = len;
        axi_if.s_axi_arsize  = size;
        axi_if.s_axi_arburst = burst;
        axi_if.s_axi_arvalid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            if (axi_if.s_axi_arready) begin
                hs = cyc;
                done = 1'b1;
                @(posedge clk);
                #1;
            end else begin
                @(negedge clk);
            end
        end
        axi_if.s_axi_arvalid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL ar_handshake: arready=%0b after 100 cycles, required 1", axi_if.s_axi_arready);
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget && obs_q.size() < exp_q.size(); k++) @(negedge clk);
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({axi_if.s_axi_arready, axi_if.s_axi_rvalid, axi_if.s_axi_rlast, axi_if.s_axi_rresp, axi_if.s_axi_rid} !== '0) begin
            errors++;
            $display("FAIL reset_ctl: arready=%0b rvalid=%0b rlast=%0b rresp=%0h rid=%0h, required all 0",
                     axi_if.s_axi_arready, axi_if.s_axi_rvalid, axi_if.s_axi_rlast, axi_if.s_axi_rresp, axi_if.s_axi_rid);
        end
        checks++;
        if (axi_if.s_axi_rdata !== '0) begin
            errors++; $display("FAIL reset_rdata: got %h, required 0", axi_if.s_axi_rdata);
        end
        checks++;
        if ({o_rd, o_raddr} !== '0) begin
            errors++; $display("FAIL reset_ram: o_rd=%0b o_raddr=%0h, required 0/0", o_rd, o_raddr);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (axi_if.s_axi_arready !== 1'b1) begin
            errors++; $display("FAIL idle_arready: got %0b, required 1", axi_if.s_axi_arready);
        end
    endtask

    task automatic test_single();
        int hs;
        clear(); rr_mode = 0;
        issue(IW'($urandom_range(0, 63)), 32'h40, 8'd0, 3'd4, 2'b01, hs);
        wait_drain(50);
        checks++;
        if (obs_a.size() != 1 || obs_a[0] !== 28'h4 || obs_acyc[0] != hs + 1) begin
            errors++; $display("FAIL single_rd: reads=%0d first addr=%0h, required 1 read of 0x4 at cycle %0d",
                               obs_a.size(), (obs_a.size() > 0) ? obs_a[0] : 28'h0, hs + 1);
        end
        checks++;
        if (obs_bcyc.size() == 0 || obs_bcyc[0] != hs + 3) begin
            errors++; $display("FAIL single_latency: first beat cycle=%0d, required %0d",
                               (obs_bcyc.size() > 0) ? obs_bcyc[0] : -1, hs + 3);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL single_nbeats: got %0d, required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL single_beat%0d: got id=%0h resp=%0h last=%0b data=%h, required id=%0h resp=%0h last=%0b data=%h",
                    i, obs_q[i].id, obs_q[i].resp, obs_q[i].last, obs_q[i].data, exp_q[i].id, exp_q[i].resp, exp_q[i].last, exp_q[i].data);
            end
        end
    endtask

    task automatic test_incr4();
        int hs;
        clear(); rr_mode = 0;
        issue(6'h05, 32'h100, 8'd3, 3'd4, 2'b01, hs);
        wait_drain(50);
        checks++;
        if (obs_a.size() != 4 || obs_q.size() != 4) begin
            errors++; $display("FAIL incr4_counts: reads=%0d beats=%0d, required 4/4", obs_a.size(), obs_q.size());
        end
        for (int i = 0; i < 4 && i < obs_a.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_a[i] !== exp_a[i] || obs_acyc[i] != hs + 1 + i) begin
                errors++; $display("FAIL incr4_rd%0d: addr=%0h cycle=%0d, required addr=%0h cycle=%0d",
                                   i, obs_a[i], obs_acyc[i], exp_a[i], hs + 1 + i);
            end
            checks++;
            if (obs_q[i] !== exp_q[i] || obs_bcyc[i] != hs + 3 + i) begin
                errors++; $display("FAIL incr4_beat%0d: last=%0b data=%h cycle=%0d, required last=%0b data=%h cycle=%0d",
                                   i, obs_q[i].last, obs_q[i].data, obs_bcyc[i], exp_q[i].last, exp_q[i].data, hs + 3 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        int hs;
        clear(); rr_mode = 2; rready_man = 1'b1;
        issue(6'h11, 32'h0000_3000, 8'd7, 3'd4, 2'b01, hs);
        for (int k = 0; k < 50 && n_acc < 1; k++) begin
            @(posedge clk); #1;
        end
        rready_man = 1'b0;
        repeat (6) @(posedge clk);
        #1 rready_man = 1'b1;
        wait_drain(100);
        rr_mode = 0;
        checks++;
        if (max_out > 2 || stab_err != 0) begin
            errors++; $display("FAIL bp_flow: max outstanding=%0d stall changes=%0d, required <=2 and 0", max_out, stab_err);
        end
        checks++;
        if (obs_a.size() != exp_a.size() || obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL bp_counts: reads=%0d beats=%0d, required %0d/%0d", obs_a.size(), obs_q.size(), exp_a.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size() && i < obs_a.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i] || obs_a[i] !== exp_a[i]) begin
                errors++; $display("FAIL bp_beat%0d: addr=%0h last=%0b data=%h, required addr=%0h last=%0b data=%h",
                                   i, obs_a[i], obs_q[i].last, obs_q[i].data, exp_a[i], exp_q[i].last, exp_q[i].data);
            end
        end
    endtask

    task automatic test_fixed_and_err();
        int hs;
        clear(); rr_mode = 0;
        issue(6'h21, 32'h200, 8'd2, 3'd4, 2'b00, hs);
        issue(6'h22, 32'h500, 8'd2, 3'd4, 2'b11, hs);
        wait_drain(100);
        checks++;
        if (obs_a.size() != 3) begin
            errors++; $display("FAIL fixed_err_nreads: got %0d, required 3 (none for reserved burst)", obs_a.size());
        end
        for (int i = 0; i < obs_a.size() && i < 3; i++) begin
            checks++;
            if (obs_a[i] !== 28'h20) begin
                errors++; $display("FAIL fixed_rd%0d: addr=%0h, required 20", i, obs_a[i]);
            end
        end
        checks++;
        if (obs_q.size() != 6) begin
            errors++; $display("FAIL fixed_err_nbeats: got %0d, required 6", obs_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL fixed_err_beat%0d: got id=%0h resp=%0h last=%0b data=%h, required id=%0h resp=%0h last=%0b data=%h",
                    i, obs_q[i].id, obs_q[i].resp, obs_q[i].last, obs_q[i].data, exp_q[i].id, exp_q[i].resp, exp_q[i].last, exp_q[i].data);
            end
        end
    endtask

    task automatic test_back_to_back();
        int hs;
        logic [IW-1:0] rid_req [3] = '{6'd1, 6'd1, 6'd2};
        logic          lst_req [3] = '{1'b0, 1'b1, 1'b1};
        clear(); rr_mode = 0;
        issue(6'd1, 32'h800, 8'd1, 3'd4, 2'b01, hs);
        issue(6'd2, 32'h900, 8'd0, 3'd4, 2'b01, hs);
        wait_drain(50);
        checks++;
        if (obs_q.size() != 3) begin
            errors++; $display("FAIL b2b_nbeats: got %0d, required 3", obs_q.size());
        end
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].id !== rid_req[i] || obs_q[i].last !== lst_req[i] || obs_q[i].data !== exp_q[i].data) begin
                errors++; $display("FAIL b2b_beat%0d: rid=%0d last=%0b data=%h, required rid=%0d last=%0b data=%h",
                                   i, obs_q[i].id, obs_q[i].last, obs_q[i].data, rid_req[i], lst_req[i], exp_q[i].data);
            end
        end
    endtask

    task automatic test_random();
        int hs;
        clear(); rr_mode = 1;
        for (int n = 0; n < 12; n++) begin
            issue(IW'($urandom), (n == 0) ? 32'hFFFF_FFC0 : $urandom, 8'($urandom_range(0, 15)),
                  3'($urandom_range(0, 4)), 2'($urandom_range(0, 3)), hs);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain(3000);
        rr_mode = 0;
        checks++;
        if (max_out > 2 || stab_err != 0) begin
            errors++; $display("FAIL rand_flow: max outstanding=%0d stall changes=%0d, required <=2 and 0", max_out, stab_err);
        end
        checks++;
        if (obs_a.size() != exp_a.size() || obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_counts: reads=%0d beats=%0d, required %0d/%0d", obs_a.size(), obs_q.size(), exp_a.size(), exp_q.size());
        end
        foreach (exp_a[i]) if (i < obs_a.size()) begin
            checks++;
            if (obs_a[i] !== exp_a[i]) begin
                errors++; $display("FAIL rand_rd%0d: addr=%0h, required %0h", i, obs_a[i], exp_a[i]);
            end
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rand_beat%0d: got id=%0h resp=%0h last=%0b data=%h, required id=%0h resp=%0h last=%0b data=%h",
                    i, obs_q[i].id, obs_q[i].resp, obs_q[i].last, obs_q[i].data, exp_q[i].id, exp_q[i].resp, exp_q[i].last, exp_q[i].data);
            end
        end
    endtask

    task automatic test_reset_mid();
        int hs;
        clear(); rr_mode = 2; rready_man = 1'b0;
        issue(6'h09, 32'h1000, 8'd7, 3'd4, 2'b01, hs);
        repeat (4) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        checks++;
        if ({axi_if.s_axi_arready, axi_if.s_axi_rvalid, axi_if.s_axi_rlast, axi_if.s_axi_rresp, axi_if.s_axi_rid,
             axi_if.s_axi_rdata, o_rd, o_raddr} !== '0) begin
            errors++; $display("FAIL midreset_outputs: arready=%0b rvalid=%0b rid=%0h rdata=%h o_rd=%0b o_raddr=%0h, required all 0",
                               axi_if.s_axi_arready, axi_if.s_axi_rvalid, axi_if.s_axi_rid, axi_if.s_axi_rdata, o_rd, o_raddr);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        clear(); rr_mode = 0;
        repeat (20) @(negedge clk);
        checks++;
        if (obs_q.size() != 0 || obs_a.size() != 0) begin
            errors++; $display("FAIL midreset_quiet: beats=%0d reads=%0d after reset, required 0/0", obs_q.size(), obs_a.size());
        end
        issue(6'h0A, 32'h2000, 8'd1, 3'd4, 2'b01, hs);
        wait_drain(50);
        checks++;
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL midreset_nbeats: got %0d, required 2", obs_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL midreset_beat%0d: got id=%0h last=%0b data=%h, required id=%0h last=%0b data=%h",
                                   i, obs_q[i].id, obs_q[i].last, obs_q[i].data, exp_q[i].id, exp_q[i].last, exp_q[i].data);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        axi_if.s_axi_arid    = '0;
        axi_if.s_axi_araddr  = '0;
        axi_if.s_axi_arlen   = '0;
        axi_if.s_axi_arsize  = '0;
        axi_if.s_axi_arburst = '0;
        axi_if.s_axi_arvalid = 1'b0;
        axi_if.s_axi_rready  = 1'b0;
        test_reset();
        test_single();
        test_incr4();
        test_backpressure();
        test_fixed_and_err();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_rd_burst2ram.md
Name: axi_rd_burst2ram

Overview:
AXI4 read-slave front end feeding the simple RAM read port (o_rd / o_raddr / i_rdata, 1-cycle read latency) used for the pixel and weights channels of the AXI-to-RAM system shell. It accepts one AR burst at a time and expands it into per-beat RAM word reads. It returns R beats through a 2-entry buffer, so RAM reads never outrun R-channel backpressure. The block is instantiated once per read channel (pixel, weights).

Parameters:
DATA_WIDTH, 128, AXI/RAM data width in bits (power of 2, >=32)
ADDR_WIDTH, 32, AXI byte-address width
ID_WIDTH, 6, AXI ID width
LSB, $clog2(DATA_WIDTH)-3, derived localparam: byte-to-word address shift

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
s_axi_arid  in  ID_WIDTH  burst ID
s_axi_araddr  in  ADDR_WIDTH  start byte address
s_axi_arlen  in  8  beats-1
s_axi_arsize  in  3  log2 bytes per beat (<= LSB)
s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  ID_WIDTH  beat ID
s_axi_rdata  out  DATA_WIDTH  beat data
s_axi_rresp  out  2  00 OKAY, 10 SLVERR
s_axi_rlast  out  1  final beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
o_rd  out  1  RAM read strobe
o_raddr  out  ADDR_WIDTH-LSB  RAM word address
i_rdata  in  DATA_WIDTH  RAM data, valid the cycle after o_rd

Behaviour:
- Reset: arready=0, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0, o_rd=0, o_raddr=0. FSM goes to IDLE. Buffer is emptied and the in-flight flag cleared.
- Reset mid-burst abandons the burst. No beat appears after rstn rises until a new AR is accepted.
- FSM IDLE: arready=1. On arvalid&&arready, latch id, addr, len, size, burst, and set beat counter=0.
  - burst 00/01/10 -> ISSUE.
  - burst 11 -> ERR.
- FSM ISSUE: arready=0. o_rd=1 when credit holds: occupancy + inflight - pop < 2.
  - pop = rvalid&&rready.
  - inflight = o_rd registered from the previous cycle.
  - Credit allows sustained 1 beat/cycle when rready is held 1.
- Address sequencing:
  - o_raddr = current byte address >> LSB.
  - INCR and WRAP: address advances by (1<<size) bytes after each issued read.
  - WRAP is implemented as INCR (no wrap boundary).
  - FIXED: address held for the whole burst.
  - Address wraps modulo 2^ADDR_WIDTH. No 4KB checks.
- ISSUE -> IDLE in the cycle the beat with counter==len is issued. The buffer drains independently, so the next AR may be accepted before the previous R beats complete.
- FSM ERR: pushes len+1 beats with rresp=10, rdata=0, and rlast on the last beat. Pushes are gated by the same credit rule. No o_rd is issued. ERR -> IDLE after the last push.
- Each beat is pushed into the buffer the cycle after o_rd. The entry is {i_rdata, id, last, resp=00}, tagged per entry.
- R channel is driven from the buffer head. rvalid=1 iff the buffer is non-empty. Outputs are held stable while rvalid&&!rready (AXI rule).
- Push and pop may occur in the same cycle. Occupancy is never >2; exceeding it is an assertion failure.
- Latency: AR handshake at cycle T -> o_rd at T+1 -> rvalid at T+3.
- arlen=0: a single beat with rlast=1.

Decomposition:
- Package axi_ram_pkg: burst encodings (BURST_FIXED/INCR/WRAP), resp codes (RESP_OKAY/SLVERR), and the state enum {IDLE, ISSUE, ERR}.
- Sub-module axi_rd_skid_fifo: 2-entry FIFO with payload {data, id, last, resp}, push/pop/count, and asynchronous active-low reset.

Test Plan:
- DATA_WIDTH=128. INCR, arlen=0, araddr=0x40 -> one o_rd with o_raddr=0x4; one R beat with rlast=1, rresp=00, rid matching.
- INCR, arlen=3, araddr=0x100, rready=1 -> o_raddr 0x10,0x11,0x12,0x13 on consecutive cycles; 4 consecutive rvalid beats with data in order; rlast only on beat 4.
- INCR, arlen=7, rready=0 for 6 cycles starting at beat 2 -> o_rd stops after at most 2 outstanding; R outputs stay stable; all 8 beats delivered in order with no loss or duplication.
- FIXED, arlen=2, araddr=0x200 -> o_raddr=0x20 three times; 3 beats.
- arburst=11, arlen=2 -> no o_rd; 3 beats with rresp=10, rdata=0, rlast on the third.
- Two back-to-back ARs (id=1, arlen=1 and id=2, arlen=0) -> rid sequence 1,1,2 with rlast on beats 2 and 3.
- rstn pulsed low in the middle of an arlen=7 burst -> all outputs return to reset values immediately; no further beats until a new AR is accepted.
